rv_instr_encoder_loader: RTL
============================

Name: rv_instr_encoder_loader

Overview:
- Inverse of the single-cycle controller's decode path.
- Accepts decoded-form instruction descriptors (operation class, register indices, alu_control code, immediate) over a valid/ready stream.
- Encodes each descriptor into a 32-bit RV32I word for the supported subset: lw, sw, R-type ALU, I-type ALU, jal, lui.
- Writes the words sequentially into instruction memory and holds the core in stall until a complete program is loaded.

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new load at word address 0.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  loader can accept a descriptor.
- in_last  input  1  descriptor is the final word of the program.
- in_op  input  3  class: 0 LW, 1 SW, 2 R, 3 I, 4 JAL, 5 LUI; 6 and 7 are illegal.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_alu_ctl  input  4  {funct3, funct7[5]}, same coding as the controller's alu_control.
- in_imm  input  32  immediate, byte offset, sign-extended form.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- word_count  output  ADDR_W+1  words written in the current load.
- cpu_hold  output  1  keeps the core stalled while high.
- done  output  1  load completed.
- error  output  1  load aborted.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Next state is IDLE.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, done=0, error=0, cpu_hold=1.
- Mid-load reset: same values on the next edge. Words already written are not undone.
- FSM states: IDLE, LOAD, DONE, ERR. in_ready = (state==LOAD), decoded from the registered state.
- IDLE:
  - start goes to LOAD with the write pointer and word_count at 0.
- LOAD:
  - Beat accepted when in_valid && in_ready.
  - One cycle after acceptance: imem_we=1, imem_addr=pointer, imem_wdata=encoded word. Pointer and word_count then increment.
  - imem_we is high for exactly one cycle per accepted beat.
  - Back-to-back beats give one write per cycle.
  - in_last accepted: FSM goes to DONE; that final write still occurs.
  - start is ignored in LOAD.
- Encoding, with f3=in_alu_ctl[3:1] and b5=in_alu_ctl[0]:
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - R: {1'b0, b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011}.
  - I, f3 = 001 or 101 (shifts): {1'b0, b5, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011}.
  - I, any other f3: {imm[11:0], rs1, f3, rd, 7'b0010011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
  - LUI: {imm[31:12], rd, 7'b0110111}.
  - Unused immediate bits are ignored, with no range check.
  - in_alu_ctl is ignored for LW, SW, JAL and LUI.
- Errors:
  - Illegal in_op (6 or 7): beat is consumed, no write occurs, next state is ERR.
  - Overflow: a beat accepted when word_count == 2**ADDR_W produces no write and goes to ERR.
  - Exactly 2**ADDR_W words ending with in_last is legal and goes to DONE.
- DONE: done=1, cpu_hold=0. start re-enters LOAD with done=0, cpu_hold=1, word_count=0.
- ERR: error=1, cpu_hold=1. start re-enters LOAD with error=0, word_count=0.
- start arriving together with a reset: reset wins.

Decomposition:
- Shared package rv_isa_pkg holds:
  - opcode constants, also consumed by the controller;
  - in_op class encodings;
  - funct3 constants.
- Sub-module rv_instr_encode: purely combinational descriptor-to-word encoder, reusable by benches as a golden model.
- The FSM, pointer and output registers live in the top module.

Test Plan:
- Reset → hold rst_n low 2 cycles while driving in_valid=1 → in_ready=0, imem_we=0, cpu_hold=1, done=0, error=0.
- Encode all classes:
  - Stimulus: start, then back-to-back beats add x3,x1,x2; sub x5,x6,x7; lw x4,8(x2); sw x4,12(x2); lui x1,0x12345; jal x1,8; addi x1,x0,-1; srai x2,x1,3 (alu_ctl 4'b1011), with in_last on the final beat.
  - Required writes, one per cycle at addresses 0..7, each 1 cycle after acceptance: 0x002081B3, 0x407302B3, 0x00812203, 0x00412623, 0x123450B7, 0x008000EF, 0xFFF00093, 0x4030D113.
  - Afterwards: done=1, cpu_hold=0, word_count=8.
- Illegal op → start, add x3,x1,x2, then in_op=6 → exactly one write (addr 0); error=1, cpu_hold=1, in_ready=0. A following start restarts at addr 0.
- Overflow → with ADDR_W=2, send 5 beats without in_last → writes at addresses 0..3, then error=1 with no fifth write. Repeat with in_last on beat 4 → done=1, no error.
- Reset mid-load → assert rst_n low after 3 accepted beats → all outputs return to reset values; the next start writes from addr 0.
- Stall handling → toggle in_valid 1,0,1,0 and check no write occurs in cycles after in_valid=0; start pulses during LOAD are ignored.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and loader types shared by
// the instruction encoder, the loader and the core controller.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] CLS_LW  = 3'd0;
  localparam logic [2:0] CLS_SW  = 3'd1;
  localparam logic [2:0] CLS_R   = 3'd2;
  localparam logic [2:0] CLS_I   = 3'd3;
  localparam logic [2:0] CLS_JAL = 3'd4;
  localparam logic [2:0] CLS_LUI = 3'd5;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu_ctl;
    logic [31:0] imm;
  } instr_desc_t;

endpackage

// File: rtl/rv_instr_encode.sv
// Combinational descriptor-to-RV32I word encoder.
// Flags op classes outside the supported subset.
module rv_instr_encode
  import rv_isa_pkg::*;
(
  input  instr_desc_t desc,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0]  f3;
  logic        b5;
  logic [31:0] imm;

  assign f3  = desc.alu_ctl[3:1];
  assign b5  = desc.alu_ctl[0];
  assign imm = desc.imm;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (desc.op)
      CLS_LW: begin
        word = {imm[11:0], desc.rs1, F3_LSW,
                desc.rd, OPC_LOAD};
      end
      CLS_SW: begin
        word = {imm[11:5], desc.rs2, desc.rs1,
                F3_LSW, imm[4:0], OPC_STORE};
      end
      CLS_R: begin
        word = {1'b0, b5, 5'b0, desc.rs2,
                desc.rs1, f3, desc.rd, OPC_OP};
      end
      CLS_I: begin
        // shifts carry funct7 in the upper immediate bits
        if (f3 == F3_SLL || f3 == F3_SR) begin
          word = {1'b0, b5, 5'b0, imm[4:0],
                  desc.rs1, f3, desc.rd, OPC_OP_IMM};
        end else begin
          word = {imm[11:0], desc.rs1, f3,
                  desc.rd, OPC_OP_IMM};
        end
      end
      CLS_JAL: begin
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], desc.rd, OPC_JAL};
      end
      CLS_LUI: begin
        word = {imm[31:12], desc.rd, OPC_LUI};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder_loader.sv
// Streams descriptors into instruction memory as encoded
// words and stalls the core until a full program is in.
module rv_instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [3:0]        in_alu_ctl,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] CAP =
    {1'b1, {ADDR_W{1'b0}}};

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  instr_desc_t desc;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;

  assign desc = '{
    op:      in_op,
    rd:      in_rd,
    rs1:     in_rs1,
    rs2:     in_rs2,
    alu_ctl: in_alu_ctl,
    imm:     in_imm
  };

  rv_instr_encode u_enc (
    .desc    (desc),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign in_ready = (state_q == ST_LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (enc_illegal || cnt_q == CAP) begin
            state_d = ST_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (in_last) state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = cnt_q;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);
  assign cpu_hold   = (state_q != ST_DONE);

endmodule
